// File: rtl/uart_msg_tx.sv
// uart_msg_tx: periodic UART message generator, 8N1 LSB first; define UART_MSG_PARITY_EN to add an even-parity bit
module uart_msg_tx #(
  parameter int                   CLOCKS_PER_BAUD = 868,
  parameter int                   MSG_LEN         = 15,
  parameter logic [8*MSG_LEN-1:0] MSG             = "Hello, World!\r\n",
  parameter logic [31:0]          PERIOD_CLKS     = 32'd100_000_000,
  parameter int                   IW              = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_trigger,
  input  logic          i_auto_en,
  output logic          o_uart_tx,
  output logic          o_busy,
  output logic          o_done,
  output logic [IW-1:0] o_index
);
`ifdef UART_MSG_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  localparam logic [23:0] BAUD_MAX = 24'(CLOCKS_PER_BAUD - 1);
  localparam logic [31:0] PER_MAX  = PERIOD_CLKS - 32'd1;
  state_t        state_q, state_d;
  logic [23:0]   baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [31:0]   per_q, per_d;
  logic          tx_q, tx_d, busy_q, busy_d, done_q, done_d;
  logic          tick, last, auto_restart, start;
  logic [7:0]    byte_d;
  function automatic logic [7:0] msg_byte(input logic [IW-1:0] i);
    msg_byte = MSG[8*(MSG_LEN-1-int'(i)) +: 8];
  endfunction
  assign tick         = baud_q == 24'd0;
  assign last         = idx_q == IW'(MSG_LEN - 1);
  assign auto_restart = i_auto_en && per_q == 32'd0;
  assign start        = i_trigger | auto_restart;
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    baud_d  = tick ? BAUD_MAX : baud_q - 24'd1;
    per_d   = !i_auto_en ? PER_MAX : per_q == 32'd0 ? PER_MAX : per_q - 32'd1;
    case (state_q)
      IDLE: begin
        state_d = start ? START : IDLE;
        baud_d  = start ? BAUD_MAX : 24'd0;
      end
      START: state_d = tick ? DATA : START;
      DATA: if (tick) begin
        bit_d = bit_q + 3'd1;
`ifdef UART_MSG_PARITY_EN
        state_d = bit_q == 3'd7 ? PARITY : DATA;
`else
        state_d = bit_q == 3'd7 ? STOP : DATA;
`endif
      end
`ifdef UART_MSG_PARITY_EN
      PARITY: state_d = tick ? STOP : PARITY;
`endif
      STOP: if (tick) begin
        state_d = last ? IDLE : START;
        idx_d   = last ? '0 : idx_q + IW'(1);
        done_d  = last;
        baud_d  = last ? 24'd0 : BAUD_MAX;
      end
      default: state_d = IDLE;
    endcase
    byte_d = msg_byte(idx_d);
    // Line value is registered from the next state so each bit appears on the edge it begins.
    tx_d   = state_d == START ? 1'b0 :
             state_d == DATA  ? byte_d[bit_d] :
`ifdef UART_MSG_PARITY_EN
             state_d == PARITY ? ^byte_d :
`endif
             1'b1;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      baud_q  <= 24'd0;
      bit_q   <= 3'd0;
      idx_q   <= '0;
      per_q   <= PER_MAX;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      per_q   <= per_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign o_uart_tx = tx_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_index   = idx_q;
endmodule
